// File: rtl/mole_field.sv
// Whack-a-mole game core: hole state, per-mole lifetime, round timer, saturating score/miss counters.
// Optional MOLE_PENALTY_EN: whacking an empty hole subtracts one point per hole (floor 0).
module mole_field #(
  parameter int N_HOLES    = 10,
  parameter int SCORE_W    = 24,
  parameter int TICK_DIV   = 50_000_000,
  parameter int LIFE_TICKS = 3,
  parameter int GAME_TICKS = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_HOLES-1:0] random,
  input  logic [N_HOLES-1:0] switch,
  output logic [N_HOLES-1:0] moles,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses,
  output logic               playing,
  output logic               game_over
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int RW = $clog2(GAME_TICKS);
  localparam int LW = $clog2(LIFE_TICKS + 1);
  localparam int HW = $clog2(N_HOLES + 1);
  localparam int SW = SCORE_W + HW;
  localparam logic [SW-1:0] MAX_EXT = {{HW{1'b0}}, {SCORE_W{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

  state_t                      state_q, state_d;
  logic [PW-1:0]               presc_q, presc_d;
  logic [RW-1:0]               round_q, round_d;
  logic [N_HOLES-1:0][LW-1:0]  life_q, life_d;
  logic [N_HOLES-1:0]          moles_q, moles_d;
  logic [N_HOLES-1:0]          sw_ref_q, sw_ref_d;
  logic [SCORE_W-1:0]          score_q, score_d;
  logic [SCORE_W-1:0]          misses_q, misses_d;

  logic [N_HOLES-1:0]          toggled, hit;
  logic [HW-1:0]               n_hit, n_exp;
  logic [SW-1:0]               sum_s, sat_s, sum_m;
  logic                        tick;
`ifdef MOLE_PENALTY_EN
  logic [N_HOLES-1:0]          empty;
  logic [HW-1:0]               n_empty;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      round_q  <= '0;
      life_q   <= '0;
      moles_q  <= '0;
      sw_ref_q <= '0;
      score_q  <= '0;
      misses_q <= '0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      round_q  <= round_d;
      life_q   <= life_d;
      moles_q  <= moles_d;
      sw_ref_q <= sw_ref_d;
      score_q  <= score_d;
      misses_q <= misses_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    round_d  = round_q;
    life_d   = life_q;
    moles_d  = moles_q;
    sw_ref_d = switch;
    score_d  = score_q;
    misses_d = misses_q;
    // Any level change since last cycle is a whack; hits use the pre-update mole map.
    toggled  = switch ^ sw_ref_q;
    hit      = toggled & moles_q;
    n_hit    = '0;
    n_exp    = '0;
    sum_s    = '0;
    sat_s    = '0;
    sum_m    = '0;
    tick     = (presc_q == PW'(TICK_DIV - 1));
`ifdef MOLE_PENALTY_EN
    empty    = toggled & ~moles_q;
    n_empty  = '0;
`endif
    for (int i = 0; i < N_HOLES; i++) begin
      n_hit = n_hit + HW'(hit[i]);
`ifdef MOLE_PENALTY_EN
      n_empty = n_empty + HW'(empty[i]);
`endif
    end

    case (state_q)
      S_IDLE, S_OVER: begin
        moles_d = '0;
        if (start) begin
          state_d  = S_PLAY;
          presc_d  = '0;
          round_d  = '0;
          life_d   = '0;
          score_d  = '0;
          misses_d = '0;
        end
      end
      S_PLAY: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick && round_q == RW'(GAME_TICKS - 1)) begin
          // Final tick ends the round; whacks landing on it are discarded.
          state_d = S_OVER;
          moles_d = '0;
        end else begin
          moles_d = moles_q & ~hit;
          if (tick) begin
            round_d = round_q + RW'(1);
            for (int i = 0; i < N_HOLES; i++) begin
              if (hit[i]) begin
                moles_d[i] = 1'b0;
              end else if (moles_q[i] && life_q[i] == LW'(1)) begin
                moles_d[i] = 1'b0;
                n_exp      = n_exp + HW'(1);
              end else if (moles_q[i]) begin
                life_d[i] = life_q[i] - LW'(1);
              end else if (random[i]) begin
                moles_d[i] = 1'b1;
                life_d[i]  = LW'(LIFE_TICKS);
              end
            end
          end
          sum_s = {{HW{1'b0}}, score_q} + SW'(n_hit);
          sat_s = (sum_s > MAX_EXT) ? MAX_EXT : sum_s;
`ifdef MOLE_PENALTY_EN
          sat_s = (sat_s > SW'(n_empty)) ? sat_s - SW'(n_empty) : '0;
`endif
          score_d  = sat_s[SCORE_W-1:0];
          sum_m    = {{HW{1'b0}}, misses_q} + SW'(n_exp);
          misses_d = (sum_m > MAX_EXT) ? SCORE_W'(MAX_EXT) : sum_m[SCORE_W-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign moles     = moles_q;
  assign score     = score_q;
  assign misses    = misses_q;
  assign playing   = (state_q == S_PLAY);
  assign game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_mole_field.sv
// Bench for mole_field: a wide-score and a 2-bit-score instance share stimulus and are
// compared against a tick-numbered reference model of the game rules.
module tb_mole_field;
  localparam int N  = 4;
  localparam int TD = 4;
  localparam int LT = 2;
  localparam int GT = 5;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] random, switch;
  logic [3:0] moles_a, moles_b;
  logic [7:0] score_a, misses_a;
  logic [1:0] score_b, misses_b;
  logic       playing_a, playing_b, over_a, over_b;

  always #5 clk = ~clk;

  mole_field #(.N_HOLES(N), .SCORE_W(8), .TICK_DIV(TD), .LIFE_TICKS(LT), .GAME_TICKS(GT)) u_dut (
    .clk(clk), .rst(rst), .start(start), .random(random), .switch(switch),
    .moles(moles_a), .score(score_a), .misses(misses_a), .playing(playing_a), .game_over(over_a)
  );

  mole_field #(.N_HOLES(N), .SCORE_W(2), .TICK_DIV(TD), .LIFE_TICKS(LT), .GAME_TICKS(GT)) u_sat (
    .clk(clk), .rst(rst), .start(start), .random(random), .switch(switch),
    .moles(moles_b), .score(score_b), .misses(misses_b), .playing(playing_b), .game_over(over_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: state 0 idle, 1 play, 2 over; moles carry the tick number they expire on.
  int       m_st, m_cyc;
  bit       m_tick;
  bit [3:0] m_lit, m_sref;
  int       m_exp [4];
  int       m_sa, m_sb, m_ma, m_mb;

  function automatic int sat_add(int v, int d, int mx);
    return (v + d > mx) ? mx : v + d;
  endfunction

  function automatic int score_rule(int v, int h, int e, int mx);
    int r;
    r = sat_add(v, h, mx);
`ifdef MOLE_PENALTY_EN
    r = (r > e) ? r - e : 0;
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_st = 0; m_cyc = 0; m_tick = 0; m_lit = '0; m_sref = '0;
    m_sa = 0; m_sb = 0; m_ma = 0; m_mb = 0;
  endtask

  task automatic model_clock();
    bit [3:0] tg;
    bit       tk;
    int       h, e, nm, tn;
    m_tick = 0;
    if (m_st != 1) begin
      m_sref = switch;
      if (start) begin
        m_st = 1; m_cyc = 0; m_lit = '0;
        m_sa = 0; m_sb = 0; m_ma = 0; m_mb = 0;
      end
      return;
    end
    tg = switch ^ m_sref;
    m_sref = switch;
    tk = (m_cyc % TD) == TD - 1;
    tn = m_cyc / TD;
    m_cyc++;
    m_tick = tk;
    if (tk && tn == GT - 1) begin
      m_st = 2; m_lit = '0;
      return;
    end
    h = $countones(tg & m_lit);
    e = $countones(tg & ~m_lit);
    nm = 0;
    for (int i = 0; i < N; i++) begin
      if (tg[i] && m_lit[i]) m_lit[i] = 1'b0;
      else if (tk) begin
        if (m_lit[i] && m_exp[i] == tn) begin
          m_lit[i] = 1'b0; nm++;
        end else if (!m_lit[i] && random[i]) begin
          m_lit[i] = 1'b1; m_exp[i] = tn + LT;
        end
      end
    end
    m_sa = score_rule(m_sa, h, e, 255);
    m_sb = score_rule(m_sb, h, e, 3);
    m_ma = sat_add(m_ma, nm, 255);
    m_mb = sat_add(m_mb, nm, 3);
  endtask

  // Drive inputs at the falling edge, clock once, advance the model, return at the next falling edge.
  task automatic step(input logic st, input logic [3:0] rnd, input logic [3:0] tog);
    start  = st;
    random = rnd;
    switch = switch ^ tog;
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic new_round();
    do_reset();
    step(1'b1, 4'b0000, 4'b0000);
  endtask

  task automatic wait_tick(input logic [3:0] rnd);
    for (int k = 0; k < TD; k++) begin
      step(1'b0, rnd, 4'b0000);
      if (m_tick) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; random = '0; switch = '0;
    model_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if ({moles_a, score_a, misses_a, playing_a, over_a} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_a: got %b/%0d/%0d/%b/%b want all zero", moles_a, score_a, misses_a, playing_a, over_a);
    end
    n_vec++;
    if ({moles_b, score_b, misses_b, playing_b, over_b} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_b: got %b/%0d/%0d/%b/%b want all zero", moles_b, score_b, misses_b, playing_b, over_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_hit();
    new_round();
    n_vec++;
    if (playing_a !== 1'b1) begin n_err++; $display("FAIL start_play: playing=%b want 1", playing_a); end
    wait_tick(4'b0011);
    n_vec++;
    if (moles_a !== 4'b0011) begin n_err++; $display("FAIL first_spawn: moles=%b want 0011", moles_a); end
    step(1'b0, 4'b0000, 4'b0001);
    n_vec++;
    if (moles_a !== 4'b0010 || score_a !== 8'd1) begin
      n_err++; $display("FAIL single_hit: moles=%b score=%0d want 0010 score 1", moles_a, score_a);
    end
  endtask

  task automatic test_double_hit();
    new_round();
    wait_tick(4'b0011);
    step(1'b0, 4'b0000, 4'b0011);
    n_vec++;
    if (moles_a !== 4'b0000 || score_a !== 8'd2 || score_b !== 2'd2) begin
      n_err++; $display("FAIL double_hit: moles=%b score=%0d/%0d want 0000 score 2/2", moles_a, score_a, score_b);
    end
  endtask

  task automatic test_expiry();
    new_round();
    wait_tick(4'b0001);
    wait_tick(4'b0000);
    n_vec++;
    if (moles_a !== 4'b0001 || misses_a !== 8'd0) begin
      n_err++; $display("FAIL expiry_alive: moles=%b misses=%0d want 0001 misses 0", moles_a, misses_a);
    end
    wait_tick(4'b0000);
    n_vec++;
    if (moles_a !== 4'b0000 || misses_a !== 8'd1 || misses_b !== 2'd1) begin
      n_err++; $display("FAIL expiry_miss: moles=%b misses=%0d/%0d want 0000 misses 1/1", moles_a, misses_a, misses_b);
    end
  endtask

  task automatic test_empty_whack();
    logic [7:0] want;
    new_round();
    step(1'b0, 4'b0000, 4'b1000);
    n_vec++;
    if (score_a !== 8'd0) begin n_err++; $display("FAIL empty_at_zero: score=%0d want 0", score_a); end
    wait_tick(4'b0001);
    step(1'b0, 4'b0000, 4'b0001);
    n_vec++;
    if (score_a !== 8'd1) begin n_err++; $display("FAIL empty_setup: score=%0d want 1", score_a); end
    step(1'b0, 4'b0000, 4'b1000);
`ifdef MOLE_PENALTY_EN
    want = 8'd0;
`else
    want = 8'd1;
`endif
    n_vec++;
    if (score_a !== want) begin n_err++; $display("FAIL empty_whack: score=%0d want %0d", score_a, want); end
  endtask

  task automatic test_saturation();
    new_round();
    wait_tick(4'b1111);
    step(1'b0, 4'b0000, 4'b1111);
    n_vec++;
    if (score_a !== 8'd4 || score_b !== 2'd3) begin
      n_err++; $display("FAIL saturate: score=%0d/%0d want 4/3", score_a, score_b);
    end
    wait_tick(4'b0001);
    wait_tick(4'b0000);
    for (int k = 0; k < TD && (m_cyc % TD) != TD - 1; k++) step(1'b0, 4'b0000, 4'b0000);
    step(1'b0, 4'b0000, 4'b0001);
    n_vec++;
    if (score_a !== 8'd5 || score_b !== 2'd3 || misses_a !== 8'd0 || moles_a !== 4'b0000) begin
      n_err++;
      $display("FAIL tick_edge_hit: score=%0d/%0d misses=%0d moles=%b want 5/3 misses 0 moles 0000",
               score_a, score_b, misses_a, moles_a);
    end
  endtask

  task automatic test_game_over();
    int         cycles;
    logic [7:0] held;
    new_round();
    cycles = 0;
    while (!over_a && cycles < 4 * GT * TD) begin
      step(1'b0, 4'($urandom), moles_a & 4'($urandom));
      cycles++;
    end
    n_vec++;
    if (cycles !== GT * TD) begin n_err++; $display("FAIL round_length: cycles=%0d want %0d", cycles, GT * TD); end
    n_vec++;
    if (over_a !== 1'b1 || playing_a !== 1'b0 || moles_a !== 4'b0000 || score_a !== 8'(m_sa)) begin
      n_err++;
      $display("FAIL game_over: over=%b playing=%b moles=%b score=%0d want 1 0 0000 %0d",
               over_a, playing_a, moles_a, score_a, m_sa);
    end
    held = 8'(m_sa);
    step(1'b0, 4'b1111, 4'b1111);
    step(1'b0, 4'b1111, 4'b0101);
    n_vec++;
    if (score_a !== held || moles_a !== 4'b0000) begin
      n_err++; $display("FAIL over_frozen: score=%0d moles=%b want %0d 0000", score_a, moles_a, held);
    end
    step(1'b1, 4'b0000, 4'b0000);
    n_vec++;
    if (playing_a !== 1'b1 || over_a !== 1'b0 || score_a !== 8'd0) begin
      n_err++; $display("FAIL restart: playing=%b over=%b score=%0d want 1 0 0", playing_a, over_a, score_a);
    end
    wait_tick(4'b1111);
    step(1'b0, 4'b0000, 4'b0000);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({moles_a, score_a, misses_a, playing_a, over_a} !== 22'd0) begin
      n_err++;
      $display("FAIL async_reset: moles=%b score=%0d misses=%0d playing=%b over=%b want all zero",
               moles_a, score_a, misses_a, playing_a, over_a);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] tg;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      tg = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      step(($urandom_range(0, 15) == 0), 4'($urandom), tg);
      n_vec++;
      if ({moles_a, score_a, misses_a, playing_a, over_a} !==
          {m_lit, 8'(m_sa), 8'(m_ma), m_st == 1, m_st == 2}) begin
        n_err++;
        $display("FAIL random_a @%0d: got %b/%0d/%0d/%b/%b want %b/%0d/%0d/%b/%b", c,
                 moles_a, score_a, misses_a, playing_a, over_a, m_lit, m_sa, m_ma, m_st == 1, m_st == 2);
      end
      n_vec++;
      if ({moles_b, score_b, misses_b, playing_b, over_b} !==
          {m_lit, 2'(m_sb), 2'(m_mb), m_st == 1, m_st == 2}) begin
        n_err++;
        $display("FAIL random_b @%0d: got %b/%0d/%0d/%b/%b want %b/%0d/%0d/%b/%b", c,
                 moles_b, score_b, misses_b, playing_b, over_b, m_lit, m_sb, m_mb, m_st == 1, m_st == 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_double_hit();
    test_expiry();
    test_empty_whack();
    test_saturation();
    test_game_over();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
